// File: rtl/timer_compare_bank_pkg.sv
// Shared register map, CTRL/STATUS bit positions and the CTRL field layout
// for the multi-channel compare/interrupt bank.
package timer_cmp_pkg;

   localparam logic [1:0] REG_COMPARE = 2'd0;
   localparam logic [1:0] REG_PERIOD  = 2'd1;
   localparam logic [1:0] REG_CTRL    = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IE       = 2;

   localparam int ST_PEND = 0;
   localparam int ST_OVR  = 1;

   // Member order puts EN in bit 0 so the struct maps directly onto CTRL.
   typedef struct packed {
      logic ie;
      logic periodic;
      logic en;
   } ctrl_t;

endpackage

// File: rtl/timer_compare_bank_if.sv
// Register bus plus interrupt outputs of the compare bank; the CPU side is the
// master, the bank is the slave.
interface timer_compare_bank_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
);
   localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [WIDTH-1:0]     count;
   logic                 we;
   logic [CH_BITS+1:0]   addr;
   logic [WIDTH-1:0]     D;
   logic [WIDTH-1:0]     Q;
   logic [CHANNELS-1:0]  timer_int;
   logic                 irq;

   modport master (output count, we, addr, D, input Q, timer_int, irq);
   modport slave  (input count, we, addr, D, output Q, timer_int, irq);

endinterface

// File: rtl/timer_compare_bank_channel.sv
// One compare channel: compare/period/ctrl registers, match detection,
// optional periodic reload and sticky PEND/OVR status with write-1-to-clear.
module timer_cmp_channel
   import timer_cmp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_count,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_we_compare,
   input  logic             i_we_period,
   input  logic             i_we_ctrl,
   input  logic             i_we_status,
   output logic [WIDTH-1:0] o_compare,
   output logic [WIDTH-1:0] o_period,
   output ctrl_t            o_ctrl,
   output logic [1:0]       o_status,
   output logic             o_int
);

   logic [WIDTH-1:0] r_compare;
   logic [WIDTH-1:0] r_period;
   ctrl_t            r_ctrl;
   logic             r_pend;
   logic             r_ovr;
   logic             w_match;
   logic             w_reload;

   assign w_match  = r_ctrl.en && (i_count == r_compare);
   assign w_reload = w_match && r_ctrl.periodic && (r_period != '0);

   // A COMPARE write beats a same-cycle match; a match beats a W1C of status.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_compare <= '0;
         r_period  <= '0;
         r_ctrl    <= '0;
         r_pend    <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         if (i_we_compare)
            r_compare <= i_wdata;
         else if (w_reload)
            r_compare <= r_compare + r_period;

         if (i_we_period)
            r_period <= i_wdata;

         if (i_we_ctrl)
            r_ctrl <= ctrl_t'(i_wdata[CTRL_IE:CTRL_EN]);

         if (i_we_compare) begin
            r_pend <= 1'b0;
            r_ovr  <= 1'b0;
         end else begin
            if (w_match)
               r_pend <= 1'b1;
            else if (i_we_status && i_wdata[ST_PEND])
               r_pend <= 1'b0;

            if (w_match && r_pend)
               r_ovr <= 1'b1;
            else if (i_we_status && i_wdata[ST_OVR])
               r_ovr <= 1'b0;
         end
      end
   end

   assign o_compare = r_compare;
   assign o_period  = r_period;
   assign o_ctrl    = r_ctrl;
   assign o_status  = {r_ovr, r_pend};
   assign o_int     = r_pend && r_ctrl.ie;

endmodule

// File: rtl/timer_compare_bank.sv
// Compare bank top: decodes {channel, reg} addresses into per-channel write
// strobes, muxes register readback and ORs the channel interrupts into irq.
module timer_compare_bank
   import timer_cmp_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
) (
   input  logic               clk,
   input  logic               rst,
   timer_compare_bank_if.slave bus
);

   localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CH_BITS-1:0]  w_ch;
   logic [1:0]          w_reg;
   logic [WIDTH-1:0]    w_compare [CHANNELS];
   logic [WIDTH-1:0]    w_period  [CHANNELS];
   ctrl_t               w_ctrl    [CHANNELS];
   logic [1:0]          w_status  [CHANNELS];
   logic [CHANNELS-1:0] w_int;
   logic [CHANNELS-1:0] w_sel;
   logic [WIDTH-1:0]    w_rdata;

   assign w_ch  = bus.addr[CH_BITS+1:2];
   assign w_reg = bus.addr[1:0];

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign w_sel[c] = bus.we && (w_ch == CH_BITS'(c));

      timer_cmp_channel #(.WIDTH(WIDTH)) u_channel (
         .clk          (clk),
         .rst          (rst),
         .i_count      (bus.count),
         .i_wdata      (bus.D),
         .i_we_compare (w_sel[c] && (w_reg == REG_COMPARE)),
         .i_we_period  (w_sel[c] && (w_reg == REG_PERIOD)),
         .i_we_ctrl    (w_sel[c] && (w_reg == REG_CTRL)),
         .i_we_status  (w_sel[c] && (w_reg == REG_STATUS)),
         .o_compare    (w_compare[c]),
         .o_period     (w_period[c]),
         .o_ctrl       (w_ctrl[c]),
         .o_status     (w_status[c]),
         .o_int        (w_int[c])
      );
   end

   // Channel indices with no channel behind them never match, so they read 0.
   always_comb begin
      w_rdata = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (w_ch == CH_BITS'(c)) begin
            case (w_reg)
               REG_COMPARE: w_rdata = w_compare[c];
               REG_PERIOD:  w_rdata = w_period[c];
               REG_CTRL:    w_rdata = WIDTH'(w_ctrl[c]);
               REG_STATUS:  w_rdata = WIDTH'(w_status[c]);
               default:     w_rdata = '0;
            endcase
         end
      end
   end

   assign bus.Q         = w_rdata;
   assign bus.timer_int = w_int;
   assign bus.irq       = |w_int;

endmodule
